// File: rtl/conf_reg_bank_pkg.sv
// Shared configuration package for the configuration-port consumer.
//   c_addr_WIDTH  : width of the configuration write address
//   c_data_WIDTH  : width of the configuration write data / each register
//   CONF_NUM_REGS : number of registers in the configuration bank
//   conf_state_e  : handshake/commit FSM states
package conf_reg_bank_pkg;

  localparam int c_addr_WIDTH  = 8;
  localparam int c_data_WIDTH  = 8;
  localparam int CONF_NUM_REGS = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } conf_state_e;

endpackage : conf_reg_bank_pkg

// File: rtl/conf_reg_bank.sv
// Configuration register bank.
// Accepts one write over a valid/ready handshake, holds it for COMMIT_CYCLES
// cycles, then commits it into the register bank and pulses cfg_update.
// Out-of-range addresses set the sticky cfg_err instead of writing.
//
// Handshake: a transfer happens at a rising edge where c_valid && c_ready.
// c_ready is registered and is high only while idle; a request seen while
// c_ready is low is ignored (not queued), so the source must hold it.
//
// Ports:
//   clk         in   clock, all logic on posedge
//   rst         in   synchronous active-high reset
//   c_addr      in   write address (ADDR_WIDTH)
//   c_data      in   write data (DATA_WIDTH)
//   c_valid     in   write request
//   c_ready     out  block can accept a write
//   cfg_regs    out  flat register bank, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   cfg_update  out  one-cycle pulse after each commit
//   cfg_err     out  sticky out-of-range flag, cleared only by reset
//   o_dbg_state out  current FSM state
module conf_reg_bank
  import conf_reg_bank_pkg::*;
#(
  parameter int ADDR_WIDTH    = c_addr_WIDTH,
  parameter int DATA_WIDTH    = c_data_WIDTH,
  parameter int NUM_REGS      = CONF_NUM_REGS,
  parameter int COMMIT_CYCLES = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          c_addr,
  input  logic [DATA_WIDTH-1:0]          c_data,
  input  logic                           c_valid,
  output logic                           c_ready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] cfg_regs,
  output logic                           cfg_update,
  output logic                           cfg_err,
  output conf_state_e                    o_dbg_state
);

  localparam int CNT_W = (COMMIT_CYCLES > 1) ? $clog2(COMMIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COMMIT_CYCLES - 1);
  // One extra bit so the range check never truncates NUM_REGS.
  localparam logic [ADDR_WIDTH:0] NUM_REGS_EXT = (ADDR_WIDTH + 1)'(NUM_REGS);

  conf_state_e             r_state;
  conf_state_e             w_state_next;
  logic                    r_ready;
  logic [CNT_W-1:0]        r_cnt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [DATA_WIDTH-1:0]   r_regs [NUM_REGS];
  logic                    r_update;
  logic                    r_err;
  logic                    w_accept;
  logic                    w_commit;
  logic                    w_in_range;

  assign w_in_range = ({1'b0, r_addr} < NUM_REGS_EXT);

  // Next-state logic
  always_comb begin
    w_accept     = 1'b0;
    w_commit     = 1'b0;
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        w_accept = c_valid && r_ready;
        if (w_accept) w_state_next = BUSY;
      end
      BUSY: begin
        if (r_cnt == '0) begin
          w_commit     = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Handshake, counter, latch and register bank
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready  <= 1'b0;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_update <= 1'b0;
      r_err    <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_update <= w_commit;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_ready <= 1'b0;
            r_cnt   <= CNT_LOAD;
            r_addr  <= c_addr;
            r_data  <= c_data;
          end else begin
            r_ready <= 1'b1;
          end
        end
        BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_ready <= 1'b1;
            if (w_in_range) begin
              for (int i = 0; i < NUM_REGS; i++) begin
                if ({1'b0, r_addr} == (ADDR_WIDTH + 1)'(i)) r_regs[i] <= r_data;
              end
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        default: r_ready <= 1'b0;
      endcase
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_flat
      assign cfg_regs[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
    end
  endgenerate

  assign c_ready     = r_ready;
  assign cfg_update  = r_update;
  assign cfg_err     = r_err;
  assign o_dbg_state = r_state;

endmodule : conf_reg_bank
